// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the nibble-serial 74181 ALU sequencer.
//   state_t      : sequencer FSM states (IDLE, RUN, DONE)
//   fn_t         : {S, M} pair describing one 74181 operation
//   FN_*         : commonly issued operations
//   NIBBLES      : nibble count for the default 16-bit datapath
//   idx_width()  : width of a counter able to address every nibble
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } fn_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int NIBBLES       = DEFAULT_WIDTH / 4;

  // Arithmetic modes use active-low carry-in: Ci_inverse=1 means "no carry".
  localparam fn_t FN_ADD = '{s: 4'b1001, m: 1'b0};  // A plus B
  localparam fn_t FN_SUB = '{s: 4'b0110, m: 1'b0};  // A minus B minus 1 (+carry)
  localparam fn_t FN_XOR = '{s: 4'b0110, m: 1'b1};  // A xor B
  localparam fn_t FN_AND = '{s: 4'b1011, m: 1'b1};  // A and B

  // ceil(log2(nibbles)), never less than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/alu_slice_181.sv
// ---------------------------------------------------------------------------
// alu_slice_181
// Combinational 4-bit 74181-compatible ALU slice, active-high data and
// active-low carries.
//   A, B        : 4-bit operands
//   S           : function select
//   M           : 1 = logic mode (carries ignored), 0 = arithmetic
//   Ci_inverse  : active-low carry-in
//   Y           : 4-bit result
//   Co_inverse  : active-low carry-out (held at 1 in logic mode)
//   P, G        : active-low group propagate / generate
//   AequalsB    : high when every bit of Y is 1
// ---------------------------------------------------------------------------
module alu_slice_181 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] S,
  input  logic       M,
  input  logic       Ci_inverse,
  output logic [3:0] Y,
  output logic       Co_inverse,
  output logic       P,
  output logic       G,
  output logic       AequalsB
);

  // p/g are the inverted propagate/generate terms of the original part;
  // gen/prop are their true-polarity versions used for the group outputs.
  logic [3:0] p, g, gen, prop;
  logic [3:0] cin_n;
  logic       carry_n;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign p[gi]    = ~(A[gi] | (B[gi] & S[0]) | (~B[gi] & S[1]));
      assign g[gi]    = ~((A[gi] & ~B[gi] & S[2]) | (A[gi] & B[gi] & S[3]));
      assign gen[gi]  = ~g[gi];
      assign prop[gi] = ~p[gi];
      // Carry term is the true carry into this bit, forced high in logic mode.
      assign Y[gi]    = (p[gi] ^ g[gi]) ^ (M | ~cin_n[gi]);
    end
  endgenerate

  // Active-low ripple: no carry out unless generated, or propagated with a
  // carry in.
  always_comb begin
    cin_n   = '0;
    carry_n = Ci_inverse;
    for (int i = 0; i < 4; i++) begin
      cin_n[i] = carry_n;
      carry_n  = g[i] & (p[i] | carry_n);
    end
  end

  assign Co_inverse = M | carry_n;
  assign P          = ~(&prop);
  assign G          = ~(gen[3]
                      | (prop[3] & gen[2])
                      | (prop[3] & prop[2] & gen[1])
                      | (prop[3] & prop[2] & prop[1] & gen[0]));
  assign AequalsB   = &Y;

endmodule

// File: rtl/alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// alu_nibble_sequencer
// WIDTH-bit ALU that pushes one nibble per cycle through a single 74181
// slice, LSB nibble first, rippling the carry through a register.
//   clk, rst_n             : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  : command handshake (A, B, S, M, Ci_inverse)
//   res_valid / res_ready  : result handshake (F, Co_inverse, AequalsB)
//   F                      : WIDTH-bit result
//   Co_inverse             : active-low carry-out of the top nibble
//   AequalsB               : high when every bit of F is 1
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             Ci_inverse,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] F,
  output logic             Co_inverse,
  output logic             AequalsB
);

  localparam int NIB_N = WIDTH / 4;
  localparam int IDX_W = idx_width(NIB_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_N - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg, b_reg, f_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg;     // active-low carry into the current nibble
  logic             aeb_acc_reg;   // AND of slice AequalsB so far
  logic             co_out_reg;
  logic             aeb_out_reg;
  logic             res_valid_reg;

  logic [3:0] slice_a, slice_b, slice_y;
  logic       slice_co, slice_p, slice_g, slice_aeb;
  logic       carry_next;

  assign slice_a = a_reg[4*idx_reg +: 4];
  assign slice_b = b_reg[4*idx_reg +: 4];

  alu_slice_181 u_slice (
    .A          (slice_a),
    .B          (slice_b),
    .S          (s_reg),
    .M          (m_reg),
    .Ci_inverse (carry_reg),
    .Y          (slice_y),
    .Co_inverse (slice_co),
    .P          (slice_p),
    .G          (slice_g),
    .AequalsB   (slice_aeb)
  );

  // Lookahead form of the nibble carry-out; in logic mode the carry chain
  // does not reach Y, so the unforced value is harmless here.
  assign carry_next = slice_g & (slice_p | carry_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      f_reg         <= '0;
      s_reg         <= '0;
      m_reg         <= 1'b0;
      carry_reg     <= 1'b1;
      aeb_acc_reg   <= 1'b1;
      co_out_reg    <= 1'b1;
      aeb_out_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            a_reg       <= A;
            b_reg       <= B;
            s_reg       <= S;
            m_reg       <= M;
            carry_reg   <= Ci_inverse;
            aeb_acc_reg <= 1'b1;
            idx_reg     <= '0;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          f_reg[4*idx_reg +: 4] <= slice_y;
          carry_reg             <= carry_next;
          aeb_acc_reg           <= aeb_acc_reg & slice_aeb;
          if (idx_reg == LAST_IDX) begin
            co_out_reg    <= slice_co;
            aeb_out_reg   <= aeb_acc_reg & slice_aeb;
            res_valid_reg <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so no command is offered while reset is held.
  assign cmd_ready  = rst_n && (state_reg == IDLE);
  assign res_valid  = res_valid_reg;
  assign F          = f_reg;
  assign Co_inverse = co_out_reg;
  assign AequalsB   = aeb_out_reg;

endmodule
